rs_enq_queue: RTL

RS_ENQ_QUEUE -- requirements
Module: rs_enq_queue

---
 rtl/rs_enq_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rs_enq_queue.sv
`default_nettype none
// ============================================================================
// Module      : rs_enq_queue
// Description : Reservation-station enqueue FIFO, 8 entries, two dispatch
//               ports in, one issue port out, flushed by redirect.
//               Optional full-cycle perf counter: define RS_ENQ_QUEUE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_enq_queue #(
    parameter int DEPTH     = 8,
    parameter int ENQ_PORTS = 2
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       io_in_0_valid,
    output logic       io_in_0_ready,
    input  logic [3:0] io_in_0_bits_ctrl_fuType,
    input  logic [7:0] io_in_0_bits_robIdx,

    input  logic       io_in_1_valid,
    output logic       io_in_1_ready,
    input  logic [3:0] io_in_1_bits_ctrl_fuType,
    input  logic [7:0] io_in_1_bits_robIdx,

    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [3:0] io_out_bits_ctrl_fuType,
    output logic [7:0] io_out_bits_robIdx,

    input  logic       io_redirect_valid,
    output logic [3:0] io_count
`ifdef RS_ENQ_QUEUE_PERF_EN
    ,
    output logic [15:0] io_perf_fullCycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NUM_W = $clog2(ENQ_PORTS + 1);
    localparam logic [3:0] READY_LIMIT = 4'(DEPTH - ENQ_PORTS);

    logic [3:0]       fu_type_mem [DEPTH];
    logic [7:0]       rob_idx_mem [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [3:0]       count;

    logic             in_ready;
    logic             fire_0;
    logic             fire_1;
    logic             deq_fire;
    logic [NUM_W-1:0] enq_num;
    logic [PTR_W-1:0] wr_ptr_1;
    logic [3:0]       count_next;

    // Readiness is judged on registered occupancy only, so both ports can be
    // accepted together without relying on a same-cycle dequeue.
    assign in_ready      = (count <= READY_LIMIT) && !io_redirect_valid;
    assign io_in_0_ready = in_ready;
    assign io_in_1_ready = in_ready;

    assign fire_0   = io_in_0_valid && in_ready;
    assign fire_1   = io_in_1_valid && in_ready;
    assign enq_num  = NUM_W'(fire_0) + NUM_W'(fire_1);
    assign wr_ptr_1 = fire_0 ? (tail_ptr + PTR_W'(1)) : tail_ptr;

    assign io_out_valid            = (count != 4'd0) && !io_redirect_valid;
    assign deq_fire                = io_out_valid && io_out_ready;
    assign io_out_bits_ctrl_fuType = fu_type_mem[head_ptr];
    assign io_out_bits_robIdx      = rob_idx_mem[head_ptr];

    assign count_next = count + 4'(enq_num) - 4'(deq_fire);
    assign io_count   = count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (io_redirect_valid) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (deq_fire) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            tail_ptr <= tail_ptr + PTR_W'(enq_num);
            count    <= count_next;
        end
    end

    // Payload is not reset; the reset term only blocks writes while held.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (fire_0) begin
                fu_type_mem[tail_ptr] <= io_in_0_bits_ctrl_fuType;
                rob_idx_mem[tail_ptr] <= io_in_0_bits_robIdx;
            end
            if (fire_1) begin
                fu_type_mem[wr_ptr_1] <= io_in_1_bits_ctrl_fuType;
                rob_idx_mem[wr_ptr_1] <= io_in_1_bits_robIdx;
            end
        end
    end

`ifdef RS_ENQ_QUEUE_PERF_EN
    logic [15:0] full_cycles;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_cycles <= '0;
        end else if ((count >= 4'(DEPTH - 1)) && (full_cycles != 16'hFFFF)) begin
            full_cycles <= full_cycles + 16'd1;
        end
    end

    assign io_perf_fullCycles = full_cycles;
`endif

endmodule
`default_nettype wire
